// File: rtl/regs_wb_arbiter.sv
// Register-file write-port arbiter (pipe over long unit) with a pending-write scoreboard for long-unit destinations.
// Optional starvation guard for the long unit is enabled by defining STARVE_GUARD_EN.
module regs_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  output logic        pipe_ready,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  input  logic        lu_issue_en,
  input  logic [4:0]  lu_issue_rd,
  input  logic [4:0]  r_addr1,
  input  logic [4:0]  r_addr2,
  output logic        hz1,
  output logic        hz2,
  output logic        w_regs_en,
  output logic [4:0]  w_regs_addr,
  output logic [31:0] w_regs_data
);

  logic        lu_force;
  logic        pipe_acc;
  logic        lu_acc;
  logic        commit_lu;
  logic        w_en_q;
  logic [4:0]  w_addr_q;
  logic [31:0] w_data_q;
  logic        src_lu_q;
  logic [31:0] pend_q;
  logic [31:0] pend_d;

  assign pipe_ready = !lu_force;
  assign lu_ready   = lu_force | !pipe_valid;
  assign pipe_acc   = pipe_valid & pipe_ready;
  assign lu_acc     = lu_valid & lu_ready;

`ifdef STARVE_GUARD_EN
  logic [3:0] starve_q;
  logic [3:0] starve_d;

  assign lu_force = (starve_q == 4'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (!lu_valid || lu_acc) starve_d = 4'd0;
    else if (!lu_force)      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) starve_q <= 4'd0;
    else      starve_q <= starve_d;
  end
`else
  assign lu_force = 1'b0;
  wire unused_starve_limit = ^STARVE_LIMIT;
`endif

  // The write leaving the output register this cycle retires a long-unit op.
  assign commit_lu = w_en_q & src_lu_q;

  always_comb begin
    pend_d = pend_q;
    if (commit_lu) pend_d[w_addr_q] = 1'b0;
    if (lu_issue_en) pend_d[lu_issue_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_en_q   <= 1'b0;
      w_addr_q <= 5'd0;
      w_data_q <= 32'd0;
      src_lu_q <= 1'b0;
      pend_q   <= 32'd0;
    end else begin
      pend_q <= pend_d;
      if (pipe_acc) begin
        w_en_q   <= (pipe_rd != 5'd0);
        w_addr_q <= pipe_rd;
        w_data_q <= pipe_data;
        src_lu_q <= 1'b0;
      end else if (lu_acc) begin
        w_en_q   <= (lu_rd != 5'd0);
        w_addr_q <= lu_rd;
        w_data_q <= lu_data;
        src_lu_q <= 1'b1;
      end else begin
        w_en_q <= 1'b0;
      end
    end
  end

  // Committing register is readable through the file's write-through path.
  assign hz1 = pend_q[r_addr1] & !(commit_lu && (w_addr_q == r_addr1));
  assign hz2 = pend_q[r_addr2] & !(commit_lu && (w_addr_q == r_addr2));

  assign w_regs_en   = w_en_q;
  assign w_regs_addr = w_addr_q;
  assign w_regs_data = w_data_q;

endmodule
